moonbase_bus_responder: RTL

MOONBASE_BUS_RESPONDER -- requirements
Module: moonbase_bus_responder

---
 rtl/moonbase_bus_responder.sv | 114 +++++++++++
 1 files changed

// File: rtl/moonbase_bus_responder.sv
// Bus responder for a nibble-serial CPU: a 12-bit address latch, a nibble-pair
// memory with a side preload port, four 8-bit output ports and four synchronized 2-bit inputs.
module moonbase_bus_responder #(
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        bus_in,
    output logic [3:0]        ram_out,
    output logic [1:0]        dev_out,
    input  logic [7:0]        gpio_in,
    output logic [31:0]       gpio_out,
    output logic [3:0]        dev_wr_pulse,
    input  logic              ld_en,
    input  logic [MEM_AW-1:0] ld_addr,
    input  logic [7:0]        ld_data
);

    localparam int DEPTH = 1 << MEM_AW;

    typedef struct packed {
        logic       strobe;
        logic       nibble;
        logic       ram_we_n;
        logic       dev_we_n;
        logic [3:0] data;
    } bus_word_t;

    bus_word_t         bus;
    logic [11:0]       lat_q, lat_d;
    logic [3:0][7:0]   port_q, port_d;
    logic [3:0]        pulse_q, pulse_d;
    logic [7:0]        sync1_q, sync2_q;
    logic [3:0]        mem_hi [DEPTH];
    logic [3:0]        mem_lo [DEPTH];
    logic [MEM_AW-1:0] mem_idx;
    logic [1:0]        port_sel;
    logic              ram_wr;
    logic              dev_wr;
    logic              lat_hi_unused;

    assign bus      = bus_word_t'(bus_in);
    assign mem_idx  = lat_q[MEM_AW-1:0];
    assign port_sel = lat_q[1:0];
    assign ram_wr   = !bus.strobe && !bus.ram_we_n && !reset;
    assign dev_wr   = !bus.strobe && !bus.dev_we_n;

    // Upper latch bits only exist so the CPU can drive them; memory aliases over them.
    assign lat_hi_unused = ^lat_q[11:MEM_AW];

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        lat_d = lat_q;
        if (bus.strobe) begin
            if (bus.nibble) begin
                lat_d[11:6] = bus_in[5:0];
            end else begin
                lat_d[5:0] = bus_in[5:0];
            end
        end
    end

    always_comb begin
        port_d  = port_q;
        pulse_d = '0;
        if (dev_wr) begin
            if (bus.nibble) begin
                port_d[port_sel][3:0] = bus.data;
                pulse_d[port_sel]     = 1'b1;
            end else begin
                port_d[port_sel][7:4] = bus.data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            lat_q   <= '0;
            port_q  <= '0;
            pulse_q <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            lat_q   <= lat_d;
            port_q  <= port_d;
            pulse_q <= pulse_d;
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
        end
    end

    // NOTE: memory has no reset so preloaded contents survive reset and it can map to RAM.
    // The preload is assigned last so it overrides a bus write to the same byte.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            if (bus.nibble) begin
                mem_lo[mem_idx] <= bus.data;
            end else begin
                mem_hi[mem_idx] <= bus.data;
            end
        end
        if (ld_en) begin
            mem_hi[ld_addr] <= ld_data[7:4];
            mem_lo[ld_addr] <= ld_data[3:0];
        end
    end

    assign ram_out      = bus.nibble ? mem_lo[mem_idx] : mem_hi[mem_idx];
    assign dev_out      = sync2_q[{port_sel, 1'b0} +: 2];
    assign gpio_out     = port_q;
    assign dev_wr_pulse = pulse_q;

endmodule
